// File: rtl/cp0.sv
// Coprocessor-0: SR/Cause/EPC/PRId, interrupt/exception arbitration, mfc0/mtc0/eret support.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0 #(
    parameter logic [31:0] PRID = 32'h2024_0707
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    localparam int unsigned DW = 32;
    localparam int unsigned IW = 6;
    localparam int unsigned EW = 5;

    logic [IW-1:0] im;
    logic          exl;
    logic          ie;
    logic          bd;
    logic [IW-1:0] ip;
    logic [EW-1:0] exccode;
    logic [DW-1:0] epc;

    logic [IW-1:0] hw;
    logic          intreq;
    logic          excreq;
    logic          wr;
    logic          wr_sr;
    logic          wr_epc;
    logic [DW-1:0] epc_base;

    assign wr       = en & ~Req;
    assign wr_sr    = wr & (CP0Add == 5'd12);
    assign wr_epc   = wr & (CP0Add == 5'd14);
    assign epc_base = BDIn ? (VPC - DW'(4)) : VPC;

`ifdef CP0_TIMER_EN
    logic [DW-1:0] count;
    logic [DW-1:0] compare;
    logic          ti;
    logic [DW-1:0] count_inc;
    logic          wr_count;
    logic          wr_compare;

    assign count_inc  = count + DW'(1);
    assign wr_count   = wr & (CP0Add == 5'd9);
    assign wr_compare = wr & (CP0Add == 5'd11);
    assign hw         = {HWInt[5] | ti, HWInt[4:0]};

    // Free-running counter; TI latches on the increment that reaches Compare.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            count <= wr_count ? CP0In : count_inc;
            if (wr_compare) begin
                compare <= CP0In;
                ti      <= 1'b0;
            end else if (!wr_count && (count_inc == compare)) begin
                ti <= 1'b1;
            end
        end
    end
`else
    assign hw = HWInt;
`endif

    assign intreq = (|(hw & im)) & ie & ~exl;
    assign excreq = (ExcCodeIn != EW'(0)) & ~exl;
    assign Req    = intreq | excreq;
    assign EPCOut = epc;

    // Architectural state; taking an exception suppresses mtc0 and eret.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im      <= '0;
            exl     <= 1'b0;
            ie      <= 1'b0;
            bd      <= 1'b0;
            ip      <= '0;
            exccode <= '0;
            epc     <= '0;
        end else begin
            ip <= hw;
            if (Req) begin
                exl     <= 1'b1;
                bd      <= BDIn;
                exccode <= intreq ? EW'(0) : ExcCodeIn;
                epc     <= {epc_base[DW-1:2], 2'b00};
            end else begin
                if (wr_sr) begin
                    im  <= CP0In[15:10];
                    exl <= CP0In[1];
                    ie  <= CP0In[0];
                end
                if (wr_epc) epc <= CP0In;
                // eret lands after any same-cycle SR write
                if (EXLClr) exl <= 1'b0;
            end
        end
    end

    always_comb begin
        CP0Out = '0;
        case (CP0Add)
            5'd12:   CP0Out = {16'b0, im, 8'b0, exl, ie};
            5'd13:   CP0Out = {bd, 15'b0, ip, 3'b0, exccode, 2'b00};
            5'd14:   CP0Out = epc;
            5'd15:   CP0Out = PRID;
`ifdef CP0_TIMER_EN
            5'd9:    CP0Out = count;
            5'd11:   CP0Out = compare;
`endif
            default: CP0Out = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios plus randomized traffic against a behavioural model.
module tb_cp0;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  CP0Add;
    logic [31:0] CP0In;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    int checks;
    int failures;

    localparam logic [31:0] PRID = 32'h2024_0707;

    cp0 dut (
        .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In),
        .CP0Out(CP0Out), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
        .HWInt(HWInt), .EXLClr(EXLClr), .EPCOut(EPCOut), .Req(Req)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Behavioural model of the architectural state
    logic [5:0]  m_im, m_ip;
    logic        m_exl, m_ie, m_bd;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_cnt, m_cmp;
    logic        m_ti;

    function automatic void model_reset();
        m_im = 0; m_ip = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_exc = 0;
        m_epc = 0; m_cnt = 0; m_cmp = 0; m_ti = 0;
    endfunction

    function automatic logic [5:0] model_hw();
        logic [5:0] h;
        h = HWInt;
`ifdef CP0_TIMER_EN
        if (m_ti) h[5] = 1'b1;
`endif
        return h;
    endfunction

    function automatic logic model_int();
        return ((model_hw() & m_im) != 6'd0) && m_ie && !m_exl;
    endfunction

    function automatic logic model_req();
        return model_int() || ((ExcCodeIn != 5'd0) && !m_exl);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] v;
        v = 32'd0;
        if (a == 5'd12) begin
            v[15:10] = m_im; v[1] = m_exl; v[0] = m_ie;
        end else if (a == 5'd13) begin
            v[31] = m_bd; v[15:10] = m_ip; v[6:2] = m_exc;
        end else if (a == 5'd14) begin
            v = m_epc;
        end else if (a == 5'd15) begin
            v = PRID;
`ifdef CP0_TIMER_EN
        end else if (a == 5'd9) begin
            v = m_cnt;
        end else if (a == 5'd11) begin
            v = m_cmp;
`endif
        end
        return v;
    endfunction

    function automatic void model_step();
        logic        req, intr, cnt_written;
        logic [5:0]  hw;
        logic [31:0] target, next_cnt;
        hw   = model_hw();
        intr = model_int();
        req  = model_req();
        cnt_written = 1'b0;
        m_ip = hw;
        if (req) begin
            m_exl = 1'b1;
            m_bd  = BDIn;
            m_exc = intr ? 5'd0 : ExcCodeIn;
            target = BDIn ? VPC - 32'd4 : VPC;
            m_epc = (target / 4) * 4;
        end else begin
            if (en) begin
                case (CP0Add)
                    5'd12: begin m_im = CP0In[15:10]; m_exl = CP0In[1]; m_ie = CP0In[0]; end
                    5'd14: m_epc = CP0In;
`ifdef CP0_TIMER_EN
                    5'd9:  cnt_written = 1'b1;
`endif
                    default: ;
                endcase
            end
            if (EXLClr) m_exl = 1'b0;
        end
`ifdef CP0_TIMER_EN
        next_cnt = cnt_written ? CP0In : m_cnt + 32'd1;
        if (!req && en && CP0Add == 5'd11) begin
            m_cmp = CP0In;
            m_ti  = 1'b0;
        end else if (!cnt_written && next_cnt == m_cmp) begin
            m_ti = 1'b1;
        end
        m_cnt = next_cnt;
`else
        next_cnt = 32'd0;
        target   = next_cnt;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; CP0Add = 0; CP0In = 0; VPC = 0; BDIn = 0;
        ExcCodeIn = 0; HWInt = 0; EXLClr = 0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        CP0Add = a;
        #1;
        d = CP0Out;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        idle_inputs();
        tick(); tick();
        reset = 1'b0;
        rd(5'd12, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_sr got=%h exp=%h", d, 32'd0); end
        rd(5'd13, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_cause got=%h exp=%h", d, 32'd0); end
        rd(5'd14, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_epc got=%h exp=%h", d, 32'd0); end
        rd(5'd15, d); checks++; if (d !== PRID) begin failures++; $display("FAIL reset_prid got=%h exp=%h", d, PRID); end
        checks++; if (Req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", Req); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        ExcCodeIn = 5'd12; VPC = 32'h0000_3010; BDIn = 0;
        #1;
        checks++; if (Req !== 1'b1) begin failures++; $display("FAIL ov_req got=%b exp=1", Req); end
        tick();
        rd(5'd14, d); checks++; if (d !== 32'h3010) begin failures++; $display("FAIL ov_epc got=%h exp=%h", d, 32'h3010); end
        rd(5'd13, d); checks++; if (d !== 32'h30) begin failures++; $display("FAIL ov_cause got=%h exp=%h", d, 32'h30); end
        rd(5'd12, d); checks++; if (d !== 32'h2) begin failures++; $display("FAIL ov_sr got=%h exp=%h", d, 32'h2); end
        checks++; if (Req !== 1'b0) begin failures++; $display("FAIL ov_nested_req got=%b exp=0", Req); end
        ExcCodeIn = 0;
    endtask

    task automatic test_delay_slot();
        logic [31:0] d;
        EXLClr = 1; tick(); EXLClr = 0;
        ExcCodeIn = 5'd12; BDIn = 1; VPC = 32'h3014;
        #1;
        checks++; if (Req !== 1'b1) begin failures++; $display("FAIL bd_req got=%b exp=1", Req); end
        tick();
        ExcCodeIn = 0; BDIn = 0;
        rd(5'd14, d); checks++; if (d !== 32'h3010) begin failures++; $display("FAIL bd_epc got=%h exp=%h", d, 32'h3010); end
        rd(5'd13, d); checks++; if (d !== 32'h8000_0030) begin failures++; $display("FAIL bd_cause got=%h exp=%h", d, 32'h8000_0030); end
    endtask

    task automatic test_int_priority();
        logic [31:0] d;
        en = 1; CP0Add = 5'd12; CP0In = 32'h401; EXLClr = 1;
        tick();
        en = 0; EXLClr = 0; HWInt = 6'b000001; ExcCodeIn = 5'd10;
        #1;
        checks++; if (Req !== 1'b1) begin failures++; $display("FAIL int_req got=%b exp=1", Req); end
        tick();
        rd(5'd13, d); checks++; if (d !== 32'h400) begin failures++; $display("FAIL int_cause got=%h exp=%h", d, 32'h400); end
        rd(5'd12, d); checks++; if (d !== 32'h403) begin failures++; $display("FAIL int_sr got=%h exp=%h", d, 32'h403); end
        checks++; if (Req !== 1'b0) begin failures++; $display("FAIL int_nested_req got=%b exp=0", Req); end
        EXLClr = 1; tick(); EXLClr = 0; ExcCodeIn = 0;
        rd(5'd12, d); checks++; if (d !== 32'h401) begin failures++; $display("FAIL eret_sr got=%h exp=%h", d, 32'h401); end
        checks++; if (Req !== 1'b1) begin failures++; $display("FAIL eret_rereq got=%b exp=1", Req); end
    endtask

    task automatic test_mtc0_suppress_and_async_reset();
        logic [31:0] d;
        en = 1; CP0Add = 5'd14; CP0In = 32'hDEAD_BEEC; VPC = 32'h5000; BDIn = 0;
        #1;
        checks++; if (Req !== 1'b1) begin failures++; $display("FAIL sup_req got=%b exp=1", Req); end
        tick();
        en = 0;
        checks++; if (EPCOut !== 32'h5000) begin failures++; $display("FAIL sup_epcout got=%h exp=%h", EPCOut, 32'h5000); end
        reset = 1; model_reset();
        #1;
        checks++; if (EPCOut !== 32'd0) begin failures++; $display("FAIL areset_epcout got=%h exp=0", EPCOut); end
        rd(5'd12, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL areset_sr got=%h exp=0", d); end
        rd(5'd13, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL areset_cause got=%h exp=0", d); end
        rd(5'd14, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL areset_epc got=%h exp=0", d); end
        idle_inputs();
        tick();
        reset = 0;
    endtask

`ifdef CP0_TIMER_EN
    task automatic test_timer();
        logic [31:0] d;
        en = 1; CP0Add = 5'd12; CP0In = 32'h8001; tick();
        CP0Add = 5'd9;  CP0In = 32'd0; tick();
        CP0Add = 5'd11; CP0In = 32'd5; tick();
        en = 0;
        tick(); tick(); tick();
        rd(5'd9, d); checks++; if (d !== 32'd4) begin failures++; $display("FAIL tmr_count got=%h exp=4", d); end
        checks++; if (Req !== 1'b0) begin failures++; $display("FAIL tmr_early_req got=%b exp=0", Req); end
        tick();
        checks++; if (Req !== 1'b1) begin failures++; $display("FAIL tmr_req got=%b exp=1", Req); end
        tick();
        rd(5'd13, d); checks++; if (d !== 32'h8000) begin failures++; $display("FAIL tmr_ip got=%h exp=%h", d, 32'h8000); end
        en = 1; CP0Add = 5'd11; CP0In = 32'd100; tick();
        en = 0; tick();
        rd(5'd13, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL tmr_clear got=%h exp=0", d); end
    endtask
`endif

    task automatic test_random();
        logic [4:0] addrs [8];
        logic [31:0] exp;
        addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd3};
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 3) == 0);
            CP0Add    = ($urandom_range(0, 4) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 7)];
            CP0In     = $urandom;
            VPC       = $urandom;
            BDIn      = 1'($urandom);
            ExcCodeIn = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
            HWInt     = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
            EXLClr    = ($urandom_range(0, 2) == 0);
            #1;
            exp = model_read(CP0Add);
            checks++; if (Req !== model_req()) begin failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", i, Req, model_req()); end
            checks++; if (CP0Out !== exp) begin failures++; $display("FAIL rnd_read cyc=%0d addr=%0d got=%h exp=%h", i, CP0Add, CP0Out, exp); end
            checks++; if (EPCOut !== m_epc) begin failures++; $display("FAIL rnd_epcout cyc=%0d got=%h exp=%h", i, EPCOut, m_epc); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model_reset();
        test_reset();
        test_overflow();
        test_delay_slot();
        test_int_priority();
        test_mtc0_suppress_and_async_reset();
`ifdef CP0_TIMER_EN
        test_timer();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0.md
Name: cp0

Overview:
- Coprocessor-0 exception/interrupt responder for the 5-stage MIPS core.
- Sits at the M-stage boundary and receives the exception codes raised upstream, including ALU arithmetic overflow (Ov, ExcCode 12) from the E stage.
- Holds SR, Cause, EPC and PRId; arbitrates interrupts against exceptions; drives Req to flush the pipeline and redirect the PC to the handler.
- Serves mfc0/mtc0/eret.

Parameters:
PRID, 32'h2024_0707, value returned on reads of register 15.

Ports:
clk  input  1  clock.
reset  input  1  asynchronous, active-high reset.
en  input  1  mtc0 write enable (M stage).
CP0Add  input  5  register number for read and write.
CP0In  input  32  mtc0 write data.
CP0Out  output  32  mfc0 read data (combinational).
VPC  input  32  PC of the M-stage instruction.
BDIn  input  1  M-stage instruction is in a branch delay slot.
ExcCodeIn  input  5  pending exception code from the pipeline; 0 = none.
HWInt  input  6  external hardware interrupt lines.
EXLClr  input  1  eret is in the M stage.
EPCOut  output  32  current EPC, used as the eret target.
Req  output  1  take exception/interrupt this cycle (combinational).

Behaviour:
- Reset: clk and reset are the only clock/reset. Reset is asynchronous and active-high. On reset, SR, Cause and EPC are all 0. Req, EPCOut and CP0Out then follow from the cleared state.
- SR (reg 12): IM=[15:10], EXL=[1], IE=[0]. All other bits read as 0.
- Cause (reg 13): BD=[31], IP=[15:10], ExcCode=[6:2]. All other bits read as 0. Cause is read-only to mtc0.
- EPC (reg 14): full 32-bit register. PRId (reg 15): returns PRID. Any other address reads 0.
- IntReq = (|(HWInt & SR.IM)) & SR.IE & ~SR.EXL.
- ExcReq = (ExcCodeIn != 0) & ~SR.EXL.
- Req = IntReq | ExcReq.
- Priority: an interrupt beats an exception. When IntReq=1, ExcCode <= 0 regardless of ExcCodeIn.
- Every cycle: Cause.IP <= HWInt. This happens whether or not Req is asserted.
- On a posedge with Req=1:
  - SR.EXL <= 1.
  - Cause.BD <= BDIn.
  - Cause.ExcCode <= IntReq ? 0 : ExcCodeIn.
  - EPC <= BDIn ? VPC-4 : VPC, with bits [1:0] forced to 0.
  - The mtc0 write is suppressed.
- mtc0 with en=1 and Req=0: reg 12 and reg 14 take CP0In. Writes to reg 12 update only the IM/EXL/IE bits. Writes to any other address are ignored.
- EXLClr=1 and Req=0: SR.EXL <= 0. If Req and EXLClr are both asserted, Req wins and EXL stays 1.
- mtc0 to SR and EXLClr in the same cycle: EXLClr is applied after the mtc0 write, so EXL ends at 0.
- EPCOut = EPC register value. A same-cycle mtc0 to EPC is not bypassed; the pipeline stalls eret behind mtc0 EPC.
- Latency: Req is combinational in the same cycle. Register updates become visible to CP0Out on the next cycle.
- Nesting: while EXL=1, Req=0 for all causes. Pending HWInt remain visible in Cause.IP.

Optional Feature:
- Macro: CP0_TIMER_EN.
- When defined:
  - Count (reg 9) increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0. An mtc0 write overrides the increment for that cycle.
  - Compare (reg 11) is writable.
  - A timer-pending flag TI sets when Count == Compare, i.e. on the increment that makes them equal. A write to Compare clears TI.
  - TI is ORed into HWInt[5] for both Cause.IP[15] and IntReq.
  - Count, Compare and TI all reset to 0.
- When undefined: regs 9 and 11 read 0, writes to them are ignored, and HWInt[5] is used unmodified.

Test Plan:
- Reset, then read regs 12/13/14/15 -> 0, 0, 0, 32'h2024_0707; Req=0.
- ExcCodeIn=12 (ALU overflow), VPC=32'h0000_3010, BDIn=0 -> Req=1 that cycle; next cycle EPC=32'h3010, Cause=32'h0000_0030, SR.EXL=1. A second ExcCodeIn=12 -> Req=0.
- ExcCodeIn=12, BDIn=1, VPC=32'h3014 -> EPC=32'h3010, Cause[31]=1.
- mtc0 SR=32'h0000_0401, then HWInt=6'b000001 with ExcCodeIn=10 in the same cycle -> Req=1, ExcCode=0 (interrupt priority). EXLClr next -> EXL=0 and Req reasserts while HWInt is held.
- Req=1 with en=1, CP0Add=14, CP0In=32'hDEAD_BEEC -> EPC holds VPC, not 32'hDEAD_BEEC. Assert reset mid-handler -> SR/Cause/EPC are 0 immediately, without waiting for a clock edge.
- [CP0_TIMER_EN] mtc0 Count=0, then mtc0 Compare=5, with SR=32'h0000_8001 -> TI set once Count reaches 5, Req=1, Cause.IP[15]=1. Write Compare -> TI=0.
